// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the decode stage that follows it:
// RV32 base opcodes, the canonical NOP, the fetch FSM state type and the
// instruction field layout.
package instr_fetch_unit_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  // Field order matches the RV32 encoding, MSB first, so a plain cast splits a word.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fields.sv
// Combinational split of a 32-bit instruction word into its RV32 fields.
// Ports:
//   instr_i   - instruction word
//   opcode_o  - [6:0]   funct3_o - [14:12]   funct7_o - [31:25]
//   rd_o      - [11:7]  rs1_o    - [19:15]   rs2_o    - [24:20]
module instr_fetch_unit_fields
  import instr_fetch_unit_pkg::*;
(
  input  logic [ILEN-1:0] instr_i,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o
);

  instr_fields_t fields;

  assign fields   = instr_fields_t'(instr_i);
  assign opcode_o = fields.opcode;
  assign funct3_o = fields.funct3;
  assign funct7_o = fields.funct7;
  assign rd_o     = fields.rd;
  assign rs1_o    = fields.rs1;
  assign rs2_o    = fields.rs2;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word read at a time to
// instruction memory, registers the returned word and holds it for decode
// until consumed. Handles downstream stall, PC redirect with kill of an
// in-flight read, and a sticky fault on a misaligned redirect target.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   imem_req_valid/ready/addr        - read request channel
//   imem_rsp_valid/data              - read response (one outstanding read)
//   stall                            - decode cannot take instr this cycle
//   redirect_valid/pc                - branch/jump target
//   instr_valid, instr, pc, pc_plus4 - registered instruction to decode
//   opcode, funct3, funct7, rd, rs1, rs2 - fields of instr
//   fetch_fault                      - misaligned redirect seen, sticky
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_WORD)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            fetch_fault
);

  fetch_state_e    state_q,       state_d;
  logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
  logic            kill_q,        kill_d;
  logic [XLEN-1:0] instr_q,       instr_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q,       fault_d;
  logic            redirect_bad;

  assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc[1:0]);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and datapath update; redirect outranks response and stall.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;

    // A response seen outside S_WAIT can only be the late answer to a read
    // abandoned by a fault; it retires the pending kill and is otherwise dropped.
    if (state_q != S_WAIT && imem_rsp_valid) begin
      kill_d = 1'b0;
    end

    if (redirect_bad) begin
      state_d       = S_FAULT;
      fault_d       = 1'b1;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      // Remember a read still in flight so its response is not taken later.
      if (state_q == S_REQ && imem_req_ready) begin
        kill_d = 1'b1;
      end
      if (state_q == S_WAIT) begin
        kill_d = !imem_rsp_valid;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
          end
          if (imem_req_ready) begin
            state_d = S_WAIT;
            kill_d  = redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (imem_rsp_valid) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              kill_d = 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d       = imem_rsp_data;
              pc_d          = fetch_pc_q;
              instr_valid_d = 1'b1;
              fetch_pc_d    = fetch_pc_q + XLEN'(4);
              state_d       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            fetch_pc_d    = redirect_pc;
            state_d       = S_REQ;
          end else if (!stall) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            state_d       = S_REQ;
          end
        end
        S_FAULT: begin
          if (redirect_valid) begin
            fault_d    = 1'b0;
            fetch_pc_d = redirect_pc;
            state_d    = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // Request channel decoded from the state register.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = fetch_pc_q;
    if (state_q == S_REQ) begin
      imem_req_valid = 1'b1;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign fetch_fault = fault_q;

  instr_fetch_unit_fields u_fields (
    .instr_i  (instr_q[ILEN-1:0]),
    .opcode_o (opcode),
    .funct3_o (funct3),
    .funct7_o (funct7),
    .rd_o     (rd),
    .rs1_o    (rs1),
    .rs2_o    (rs2)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fetch_fault;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus knobs (percentages and memory latency range).
  int p_stall = 0;
  int p_redir = 0;
  int p_ready = 0;
  int min_lat = 0;
  int max_lat = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc    = '0;

  // Reference model: the address the next delivered instruction must have,
  // and whether a misaligned redirect is outstanding.
  logic [31:0] exp_pc;
  bit          exp_fault;
  int          n_deliv = 0;

  // Memory model: at most one read outstanding.
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;  // addi x1,x0,5
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] rand_target();
    int unsigned k;
    logic [31:0] t;
    k = $urandom_range(0, 9);
    t = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    if (k == 0) t = 32'hFFFF_FFF8;
    if (k == 1) t = 32'hFFFF_FFFC;
    if (k >= 8) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic reset_model();
    exp_pc    = RST_PC;
    exp_fault = 1'b0;
  endtask

  // Compare every visible output with what the model says must be there.
  task automatic model_check();
    logic [31:0] w;
    w = instr_valid ? mem_word(exp_pc) : NOP;
    check_eq("fault", 32'(fetch_fault), 32'(exp_fault));
    check_eq("req_and_valid", 32'(instr_valid & imem_req_valid), 32'd0);
    if (exp_fault) begin
      check_eq("fault_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("fault_instr_valid", 32'(instr_valid), 32'd0);
    end
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_pc);
    check_eq("instr", instr, w);
    if (instr_valid) begin
      check_eq("pc", pc, exp_pc);
      check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
    end
    check_eq("opcode", 32'(opcode), 32'(w[6:0]));
    check_eq("rd", 32'(rd), 32'(w[11:7]));
    check_eq("funct3", 32'(funct3), 32'(w[14:12]));
    check_eq("rs1", 32'(rs1), 32'(w[19:15]));
    check_eq("rs2", 32'(rs2), 32'(w[24:20]));
    check_eq("funct7", 32'(funct7), 32'(w[31:25]));
  endtask

  // One clock: check outputs, drive inputs for the next edge, advance model.
  task automatic cycle();
    if (!rst) model_check();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_req_ready = !pend && !imem_rsp_valid && ($urandom_range(0, 99) < p_ready);
    stall          = ($urandom_range(0, 99) < p_stall);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if ($urandom_range(0, 99) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom();
    end
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_cnt  = $urandom_range(min_lat, max_lat);
      end
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin
          exp_fault = 1'b1;
        end else begin
          exp_fault = 1'b0;
          exp_pc    = redirect_pc;
        end
      end else if (instr_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int  d0;
    bit  saw_top;
    bit  found;

    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    reset_model();
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("rst_req_addr", imem_req_addr, RST_PC);

    // First fetch with single-cycle memory.
    rst = 1'b0;
    p_ready = 100;
    cycle();
    check_eq("t1_wait_valid", 32'(instr_valid), 32'd0);
    check_eq("t1_wait_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check_eq("t1_valid", 32'(instr_valid), 32'd1);
    check_eq("t1_instr", instr, 32'h0050_0093);
    check_eq("t1_opcode", 32'(opcode), 32'h13);
    check_eq("t1_rd", 32'(rd), 32'd1);
    check_eq("t1_pc", pc, 32'h0);
    check_eq("t1_pc_plus4", pc_plus4, 32'h4);

    // Stall holds the instruction.
    p_stall = 100;
    repeat (4) begin
      cycle();
      check_eq("t2_hold_valid", 32'(instr_valid), 32'd1);
      check_eq("t2_hold_instr", instr, 32'h0050_0093);
      check_eq("t2_hold_req", 32'(imem_req_valid), 32'd0);
    end
    p_stall = 0;
    cycle();
    check_eq("t2_next_req", 32'(imem_req_valid), 32'd1);
    check_eq("t2_next_addr", imem_req_addr, 32'h4);

    // Redirect while waiting; the old response is dropped.
    min_lat = 1;
    max_lat = 1;
    cycle();
    force_redir = 1'b1;
    force_pc    = 32'h100;
    cycle();
    cycle();
    check_eq("t3_old_dropped", 32'(instr_valid), 32'd0);
    check_eq("t3_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t3_req_addr", imem_req_addr, 32'h100);

    // Misaligned redirect faults; an aligned one recovers.
    p_ready     = 0;
    force_redir = 1'b1;
    force_pc    = 32'h102;
    cycle();
    check_eq("t4_fault", 32'(fetch_fault), 32'd1);
    check_eq("t4_fault_req", 32'(imem_req_valid), 32'd0);
    cycle();
    cycle();
    check_eq("t4_fault_sticky", 32'(fetch_fault), 32'd1);
    force_redir = 1'b1;
    force_pc    = 32'h200;
    cycle();
    check_eq("t4_fault_clear", 32'(fetch_fault), 32'd0);
    check_eq("t4_req_addr", imem_req_addr, 32'h200);

    // Request held while memory is not ready, then reset mid-wait.
    repeat (5) begin
      cycle();
      check_eq("t5_req_held", 32'(imem_req_valid), 32'd1);
      check_eq("t5_addr_held", imem_req_addr, 32'h200);
    end
    p_ready = 100;
    min_lat = 3;
    max_lat = 3;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check_eq("t5_async_valid", 32'(instr_valid), 32'd0);
    check_eq("t5_async_addr", imem_req_addr, RST_PC);
    check_eq("t5_async_req", 32'(imem_req_valid), 32'd1);
    cycle();
    rst = 1'b0;
    reset_model();
    min_lat = 0;
    max_lat = 0;
    cycle();
    cycle();
    check_eq("t5_late_ignored", 32'(instr_valid), 32'd0);
    check_eq("t5_late_addr", imem_req_addr, RST_PC);
    for (int k = 0; k < 20 && !instr_valid; k++) cycle();
    check_eq("t5_refetch_valid", 32'(instr_valid), 32'd1);
    check_eq("t5_refetch_pc", pc, RST_PC);

    // Randomized traffic with occasional resets.
    p_stall = 30;
    p_redir = 5;
    p_ready = 60;
    min_lat = 0;
    max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        reset_model();
      end else begin
        cycle();
      end
    end
    check_eq("random_progress", 32'(n_deliv > 100), 32'd1);

    // Drain: clean redirect, then a steady stream must flow.
    p_stall = 0;
    p_redir = 0;
    p_ready = 100;
    max_lat = 0;
    force_redir = 1'b1;
    force_pc    = 32'h40;
    d0 = n_deliv;
    for (int k = 0; k < 200 && (n_deliv - d0) < 5; k++) cycle();
    check_eq("drain_progress", 32'((n_deliv - d0) >= 5), 32'd1);

    // Fetch PC wraps from the top of the address space to zero.
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    saw_top = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle();
      if (instr_valid && pc == 32'hFFFF_FFFC) saw_top = 1'b1;
      if (saw_top && imem_req_valid && imem_req_addr == 32'h0) found = 1'b1;
    end
    check_eq("t6_wrap_addr", 32'(found), 32'd1);
    check_eq("t6_no_fault", 32'(fetch_fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
